ram_banked: RTL and testbench

Parametrised, single-port synchronous RAM built from `2^BANK_BITS` equal banks, with bank select decoded from the upper address bits. It is the general successor to the fixed 256×8 sixteen-bank memory. It adds a registered read port with a valid strobe, a req/ready handshake, and a hardware bulk-clear sequencer. It sits between the datapath or controller and storage wherever the design needs a scratch or table memory of configurable size.

---
 rtl/ram_banked_if.sv | 29 ++
 rtl/ram_banked.sv | 135 +++++++++++++
 tb/tb_ram_banked.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_banked_if.sv
// ram_banked_if: request/response bundle for ram_banked.
//   master: drives en, req, rw, addr, data_in, clr; observes the rest.
//   slave : the memory side; drives ready, data_out, rvalid, busy, clr_done.
interface ram_banked_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              en;
    logic              req;
    logic              rw;        // 1 = write, 0 = read
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic              clr;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              rvalid;
    logic              busy;
    logic              clr_done;

    modport master (
        output en, req, rw, addr, data_in, clr,
        input  ready, data_out, rvalid, busy, clr_done
    );

    modport slave (
        input  en, req, rw, addr, data_in, clr,
        output ready, data_out, rvalid, busy, clr_done
    );
endinterface

// File: rtl/ram_banked.sv
// ram_banked: single-port synchronous RAM split into 2^BANK_BITS banks,
// bank chosen by the top address bits. Registered read port with rvalid
// strobe, req/ready handshake and a bulk-clear sequencer that zeroes the
// whole array one word per cycle.
//   clk, rst_n : clock, async active-low reset
//   bus        : ram_banked_if.slave (en, req, rw, addr, data_in, clr in;
//                ready, data_out, rvalid, busy, clr_done out)

// One bank: write on we, combinational read gated by re so idle banks
// present zero on their read bus.
module ram_bank #(
    parameter int OFF_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**OFF_W];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) mem[off] <= wdata;
    end

    assign rdata = re ? mem[off] : '0;
endmodule

module ram_banked #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BANK_BITS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_banked_if.slave  bus
);
    localparam int NBANK = 1 << BANK_BITS;
    localparam int OFF_W = ADDR_W - BANK_BITS;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              clr_done_q, clr_done_nxt;
    logic [DATA_W-1:0] data_out_q;
    logic              rvalid_q;

    logic              clearing;
    logic              acc, wr_acc, rd_acc;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [BANK_BITS-1:0] bank_sel;
    logic [OFF_W-1:0]  bank_off;

    logic [NBANK-1:0]             bank_we, bank_re;
    logic [NBANK-1:0][DATA_W-1:0] bank_rdata;

    assign clearing  = (state == CLEAR);
    assign bus.ready = (state == IDLE) && bus.en && !bus.clr;
    assign bus.busy  = clearing;

    assign acc    = bus.req && bus.ready;
    assign wr_acc = acc && bus.rw;
    assign rd_acc = acc && !bus.rw;

    // The sequencer owns the port while clearing; ready is low then, so
    // no user access can collide with it.
    assign mem_addr  = clearing ? cnt : bus.addr;
    assign mem_wdata = clearing ? '0  : bus.data_in;
    assign mem_we    = clearing || wr_acc;
    assign bank_sel  = mem_addr[ADDR_W-1 -: BANK_BITS];
    assign bank_off  = mem_addr[OFF_W-1:0];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        assign bank_we[b] = mem_we && (bank_sel == BANK_BITS'(b));
        assign bank_re[b] = rd_acc && (bank_sel == BANK_BITS'(b));

        ram_bank #(.OFF_W(OFF_W), .DATA_W(DATA_W)) u_bank (
            .clk  (clk),
            .we   (bank_we[b]),
            .re   (bank_re[b]),
            .off  (bank_off),
            .wdata(mem_wdata),
            .rdata(bank_rdata[b])
        );
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        clr_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en && bus.clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                // Last word is written on this edge.
                if (cnt == '1) begin
                    state_nxt    = IDLE;
                    clr_done_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            clr_done_q <= 1'b0;
            data_out_q <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            clr_done_q <= clr_done_nxt;
            rvalid_q   <= rd_acc;
            if (rd_acc) data_out_q <= bank_rdata[bank_sel];
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.clr_done = clr_done_q;
endmodule

// File: tb/tb_ram_banked.sv
// tb_ram_banked: directed bench for ram_banked, default geometry (256x8,
// 16 banks) plus a 64x16 / 4-bank instance. Inputs are driven and outputs
// sampled on the falling edge.
module tb_ram_banked;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_banked_if #(.ADDR_W(8), .DATA_W(8))  bus ();
    ram_banked_if #(.ADDR_W(6), .DATA_W(16)) bus6 ();

    ram_banked #(.ADDR_W(8), .DATA_W(8), .BANK_BITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    ram_banked #(.ADDR_W(6), .DATA_W(16), .BANK_BITS(2)) dut6 (
        .clk(clk), .rst_n(rst_n), .bus(bus6)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.req = 1'b1; bus.rw = 1'b1; bus.addr = a; bus.data_in = d;
        @(negedge clk);
        bus.req = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] q, output logic v);
        bus.req = 1'b1; bus.rw = 1'b0; bus.addr = a;
        @(negedge clk);
        q = bus.data_out; v = bus.rvalid;
        bus.req = 1'b0;
    endtask

    task automatic fill(input logic [7:0] d, input bit own);
        for (int i = 0; i < 256; i++) wr(8'(i), own ? 8'(i) : d);
    endtask

    // Count reads in [lo,hi] that miss the expected word or lack rvalid.
    task automatic scan(input int lo, input int hi, input logic [7:0] d,
                        input bit own, output int bad);
        logic [7:0] q;
        logic v;
        bad = 0;
        for (int i = lo; i <= hi; i++) begin
            rd(8'(i), q, v);
            if (q !== (own ? 8'(i) : d) || v !== 1'b1) bad++;
        end
    endtask

    // Runs out a clear already in progress (busy sampled high). Counts busy
    // cycles and any cycle where ready/rvalid/clr_done misbehave; fires a
    // read request partway through that must be ignored.
    task automatic run_clear(output int cyc, output int bad);
        cyc = 0; bad = 0;
        while (bus.busy === 1'b1 && cyc < 1000) begin
            if (bus.ready !== 1'b0 || bus.rvalid !== 1'b0 || bus.clr_done !== 1'b0) bad++;
            if (cyc == 100) begin
                bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 8'h20;
            end else begin
                bus.req = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.req = 1'b0;
    endtask

    initial begin
        logic [7:0]  q;
        logic        v;
        int          cyc, bad, seen;

        bus.en = 1'b1; bus.req = 1'b0; bus.rw = 1'b0; bus.addr = '0;
        bus.data_in = '0; bus.clr = 1'b0;
        bus6.en = 1'b1; bus6.req = 1'b0; bus6.rw = 1'b0; bus6.addr = '0;
        bus6.data_in = '0; bus6.clr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_rvalid",   bus.rvalid, 0);
        chk("rst_busy",     bus.busy, 0);
        chk("rst_clr_done", bus.clr_done, 0);
        chk("rst_ready",    bus.ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write/read-back
        wr(8'h00, 8'hA5); wr(8'h1F, 8'h3C); wr(8'hF0, 8'hFF); wr(8'hFF, 8'h01);
        chk("wr_no_rvalid", bus.rvalid, 0);
        rd(8'h00, q, v); chk("rd_00", q, 8'hA5); chk("rv_00", v, 1);
        rd(8'h1F, q, v); chk("rd_1f", q, 8'h3C); chk("rv_1f", v, 1);
        rd(8'hF0, q, v); chk("rd_f0", q, 8'hFF); chk("rv_f0", v, 1);
        rd(8'hFF, q, v); chk("rd_ff", q, 8'h01); chk("rv_ff", v, 1);
        @(negedge clk);
        chk("rvalid_pulse", bus.rvalid, 0);
        chk("dout_hold", bus.data_out, 8'h01);
        wr(8'h40, 8'h99);
        chk("wr_keeps_dout", bus.data_out, 8'h01);
        chk("wr_keeps_rv", bus.rvalid, 0);

        // en low blocks access
        bus.en = 1'b0;
        #1 chk("en_lo_ready", bus.ready, 0);
        bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 8'h00;
        @(negedge clk);
        chk("en_lo_no_rd", bus.rvalid, 0);
        bus.req = 1'b0; bus.en = 1'b1;

        // Bank isolation
        fill(8'h00, 1'b1);
        rd(8'h12, q, v); chk("iso_12", q, 8'h12);
        rd(8'h02, q, v); chk("iso_02", q, 8'h02);
        scan(0, 255, 8'h00, 1'b1, bad); chk("iso_all_bad", 32'(bad), 0);

        // Bulk clear
        fill(8'h55, 1'b0);
        bus.clr = 1'b1;
        #1 chk("clr_ready_lo", bus.ready, 0);
        @(negedge clk);
        bus.clr = 1'b0;
        chk("clr_busy_up", bus.busy, 1);
        run_clear(cyc, bad);
        chk("clr_cycles", 32'(cyc), 256);
        chk("clr_bad_cyc", 32'(bad), 0);
        chk("clr_done_hi", bus.clr_done, 1);
        chk("clr_ready_back", bus.ready, 1);
        chk("clr_req_ignored", bus.rvalid, 0);
        @(negedge clk);
        chk("clr_done_pulse", bus.clr_done, 0);
        scan(0, 255, 8'h00, 1'b0, bad); chk("clr_zero_bad", 32'(bad), 0);

        // clr and req together: clr wins
        wr(8'h10, 8'h66);
        bus.clr = 1'b1; bus.req = 1'b1; bus.rw = 1'b0; bus.addr = 8'h10;
        #1 chk("both_ready_lo", bus.ready, 0);
        @(negedge clk);
        bus.clr = 1'b0; bus.req = 1'b0;
        chk("both_no_rvalid", bus.rvalid, 0);
        chk("both_busy", bus.busy, 1);
        run_clear(cyc, bad);
        chk("both_clr_cycles", 32'(cyc), 256);
        chk("both_clr_done", bus.clr_done, 1);

        // Reset mid-clear
        fill(8'h77, 1'b0);
        rd(8'h05, q, v); chk("pre_rst_rd", q, 8'h77);
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        repeat (99) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_data_out", bus.data_out, 0);
        chk("abort_rvalid",   bus.rvalid, 0);
        chk("abort_busy",     bus.busy, 0);
        chk("abort_clr_done", bus.clr_done, 0);
        chk("abort_ready",    bus.ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            if (bus.clr_done !== 1'b0 || bus.busy !== 1'b0) seen++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(seen), 0);
        rd(8'h00, q, v); chk("abort_rd_00", q, 8'h00);
        rd(8'h62, q, v); chk("abort_rd_62", q, 8'h00);
        rd(8'h64, q, v); chk("abort_rd_64", q, 8'h77);
        rd(8'hFF, q, v); chk("abort_rd_ff", q, 8'h77);
        scan(8'h00, 8'h62, 8'h00, 1'b0, bad); chk("abort_lo_bad", 32'(bad), 0);
        scan(8'h64, 8'hFF, 8'h77, 1'b0, bad); chk("abort_hi_bad", 32'(bad), 0);

        // 64x16, 4 banks
        bus6.req = 1'b1; bus6.rw = 1'b1; bus6.addr = 6'h3F; bus6.data_in = 16'hBEEF;
        @(negedge clk);
        bus6.addr = 6'h00; bus6.data_in = 16'h1234;
        @(negedge clk);
        bus6.rw = 1'b0; bus6.addr = 6'h3F;
        @(negedge clk);
        chk("p6_rd_3f", bus6.data_out, 16'hBEEF);
        chk("p6_rv_3f", bus6.rvalid, 1);
        bus6.addr = 6'h00;
        @(negedge clk);
        chk("p6_rd_00", bus6.data_out, 16'h1234);
        bus6.req = 1'b0;
        bus6.clr = 1'b1;
        @(negedge clk);
        bus6.clr = 1'b0;
        cyc = 0;
        while (bus6.busy === 1'b1 && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        chk("p6_clr_cycles", 32'(cyc), 64);
        chk("p6_clr_done", bus6.clr_done, 1);
        bus6.req = 1'b1; bus6.rw = 1'b0; bus6.addr = 6'h3F;
        @(negedge clk);
        bus6.req = 1'b0;
        chk("p6_rd_cleared", bus6.data_out, 16'h0000);
        chk("p6_rv_cleared", bus6.rvalid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
